instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the decode-stage control unit.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions, together with their PCs, in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the buffer and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, credited imem requests, fetch buffer, redirect drain
//
// Purpose:
//   Owns the fetch PC and issues in-order word requests to instruction memory.
//   Returned words are paired with their request address and buffered in a
//   small FIFO that feeds decode. A redirect flushes the buffer and retargets
//   the PC. Responses that were already in flight are counted and discarded.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     request handshake to instruction memory
//   imem_req_addr            word-aligned fetch address (current PC)
//   imem_rsp_valid/data      in-order responses, at least 1 cycle after accept
//   redirect_valid/pc        branch/jump redirect; target low bits ignored
//   if_valid/ready           handshake to decode
//   if_pc/if_instr           head-of-buffer PC and instruction word

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_W    = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_W = RESET_PC & ~32'h3;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Wrap-around increment so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Control state
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          init_q, init_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  // In-flight address queue: one entry per accepted, not yet returned request
  logic [31:0]   aq_addr_q [DEPTH];
  logic [31:0]   aq_addr_d [DEPTH];
  logic [PW-1:0] aq_rd_q, aq_rd_d;
  logic [PW-1:0] aq_wr_q, aq_wr_d;

  // Fetch buffer: {pc, instr} pairs waiting for decode
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_pc_d    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic [PW-1:0] buf_rd_q, buf_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  logic          req_fire;
  logic          rsp_live;
  logic          if_fire;
  logic          buf_push;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] credit_used;
  logic [31:0]   redirect_aligned;

  // In RUN the drop count is zero; in DRAIN the in-flight count is zero.
  // Their sum is therefore the number of responses still owed by memory.
  assign outstanding      = inflight_q + drop_q;
  assign credit_used      = inflight_q + buf_cnt_q;
  assign redirect_aligned = redirect_pc & ~32'h3;

  // init_q holds requests off for the first cycle after reset.
  assign imem_req_valid = !rst && !init_q && (state_q == ST_RUN) &&
                          !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;

  // Decode outputs come straight from buffer flops; no path from imem_rsp.
  assign if_valid = (buf_cnt_q != '0);
  assign if_pc    = if_valid ? buf_pc_q[buf_rd_q]    : '0;
  assign if_instr = if_valid ? buf_instr_q[buf_rd_q] : '0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_live = imem_rsp_valid && (outstanding != '0);
  assign if_fire  = if_valid && if_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    init_d      = 1'b0;
    inflight_d  = inflight_q;
    drop_d      = drop_q;
    aq_addr_d   = aq_addr_q;
    aq_rd_d     = aq_rd_q;
    aq_wr_d     = aq_wr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_rd_d    = buf_rd_q;
    buf_wr_d    = buf_wr_q;
    buf_cnt_d   = buf_cnt_q;
    buf_push    = 1'b0;

    if (redirect_valid) begin
      // Everything queued or buffered is stale. A response arriving in this
      // same cycle is one of the owed ones and is simply not stored.
      pc_d       = redirect_aligned;
      aq_rd_d    = '0;
      aq_wr_d    = '0;
      inflight_d = '0;
      buf_rd_d   = '0;
      buf_wr_d   = '0;
      buf_cnt_d  = '0;
      drop_d     = outstanding - CW'(rsp_live);
      state_d    = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (state_q == ST_RUN) begin
        if (req_fire) begin
          aq_addr_d[aq_wr_q] = pc_q;
          aq_wr_d            = ptr_inc(aq_wr_q);
          pc_d               = pc_q + 32'd4;
        end
        if (rsp_live) begin
          buf_push              = 1'b1;
          buf_pc_d[buf_wr_q]    = aq_addr_q[aq_rd_q];
          buf_instr_d[buf_wr_q] = imem_rsp_data;
          buf_wr_d              = ptr_inc(buf_wr_q);
          aq_rd_d               = ptr_inc(aq_rd_q);
        end
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_live);
      end else begin
        if (rsp_live) begin
          drop_d = drop_q - 1'b1;
          if (drop_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end

      if (if_fire) begin
        buf_rd_d = ptr_inc(buf_rd_q);
      end
      buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(if_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC_W;
      init_q     <= 1'b1;
      inflight_q <= '0;
      drop_q     <= '0;
      aq_rd_q    <= '0;
      aq_wr_q    <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      init_q     <= init_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      aq_rd_q    <= aq_rd_d;
      aq_wr_q    <= aq_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the pointers/counts.
  always_ff @(posedge clk) begin
    aq_addr_q   <= aq_addr_d;
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] acc_log [$];
  logic [31:0] model_pc;
  int          cyc;
  int          lat;
  int          acc_cnt;
  int          deliv_cnt;
  int          checks;
  int          errors;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Negedge: observe the handshakes that complete at the coming edge and
  // update the reference model and scoreboard.
  task automatic mon();
    req_t        r;
    logic [31:0] e;
    @(negedge clk);
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      model_pc = RESET_PC & ~32'h3;
      return;
    end
    if (imem_rsp_valid) r = mem_q.pop_front();
    if (redirect_valid) begin
      chk("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
    end else begin
      if (if_valid && if_ready) begin
        deliv_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_delivery", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", if_pc, e);
          chk("deliver_instr", if_instr, instr_of(e));
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back(model_pc);
        acc_log.push_back(imem_req_addr);
        acc_cnt++;
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  // Posedge + 1: memory model presents the oldest due response.
  task automatic adv();
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic tick();
    mon();
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_if_valid(input string tag, input int lim);
    int n;
    n = 0;
    mon();
    while (!if_valid && n < lim) begin
      adv();
      mon();
      n++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int acc0;
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    lat            = 1;
    acc_cnt        = 0;
    deliv_cnt      = 0;
    model_pc       = RESET_PC;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;

    // Reset values, first-fetch latency, streaming
    tick();
    mon();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    adv();
    rst = 1'b0;
    mon();
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    chk("post_rst_if_pc", if_pc, 32'd0);
    adv();
    mon();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    adv();
    mon();
    chk("lat1_if_valid", 32'(if_valid), 32'd0);
    adv();
    mon();
    chk("lat2_if_valid", 32'(if_valid), 32'd1);
    chk("lat2_if_pc", if_pc, RESET_PC);
    adv();
    repeat (20) tick();

    // Decode stall: credits limit fetch to DEPTH requests
    if_ready = 1'b0;
    do_reset();
    acc0 = acc_cnt;
    acc_log.delete();
    for (int i = 0; i < 8; i++) begin
      mon();
      if (if_valid) begin
        chk("hold_pc", if_pc, 32'h0);
        chk("hold_instr", if_instr, instr_of(32'h0));
      end
      adv();
    end
    mon();
    chk("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    adv();
    if_ready = 1'b1;
    repeat (10) tick();
    chk("resume_count", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) chk("resume_addr", acc_log[2], 32'h8);

    // Redirect with two requests in flight, latency 3
    lat = 3;
    do_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    mon();
    chk("drain1_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain1_if_valid", 32'(if_valid), 32'd0);
    adv();
    mon();
    chk("drain2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain2_if_valid", 32'(if_valid), 32'd0);
    adv();
    mon();
    chk("post_drain_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_drain_addr", imem_req_addr, 32'h100);
    adv();
    wait_if_valid("redir_valid_timeout", 10);
    chk("redir_first_pc", if_pc, 32'h100);
    adv();
    repeat (10) tick();

    // Redirect coincident with decode pop and an arriving response
    lat = 1;
    do_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    mon();
    chk("coinc_pre_if_valid", 32'(if_valid), 32'd1);
    adv();
    redirect_valid = 1'b0;
    mon();
    chk("coinc_if_flushed", 32'(if_valid), 32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_aligned_addr", imem_req_addr, 32'h200);
    adv();
    wait_if_valid("coinc_valid_timeout", 10);
    chk("coinc_first_pc", if_pc, 32'h200);
    chk("coinc_first_instr", if_instr, instr_of(32'h200));
    adv();
    repeat (6) tick();

    // PC wrap from the top of the address space
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete();
    repeat (8) tick();
    chk("wrap_count", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      chk("wrap_first", acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_second", acc_log[1], 32'h0);
    end

    // Reset mid-stream with a full buffer
    if_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    mon();
    chk("full_if_valid", 32'(if_valid), 32'd1);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    adv();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon();
    chk("midrst_if_valid", 32'(if_valid), 32'd0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_if_pc", if_pc, 32'd0);
    adv();
    mon();
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_addr", imem_req_addr, RESET_PC);
    adv();
    if_ready = 1'b1;
    repeat (10) tick();

    chk("delivery_total", 32'(deliv_cnt >= 30), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
